// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants.
//   DEF_DATA_W / DEF_ADDR_W : default register width and register-number width
//   ZERO_REG                : hardwired-zero register number (R0)
//   SP / FP / RA            : well-known register numbers
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int ZERO_REG = 0;
  localparam int SP       = 29;
  localparam int FP       = 30;
  localparam int RA       = 31;

endpackage

// File: rtl/regfile.sv
// regfile: 2**ADDR_W x DATA_W register file, one write port, two read ports.
//   clk                 : clock, all state changes on its rising edge
//   reset               : synchronous active-high, clears every register
//   wr_num/wr_data/wr_en: write port, takes effect on the rising edge
//   rd0_num/rd0_data    : combinational read port 0
//   rd1_num/rd1_data    : combinational read port 1
// R0 always reads as zero and ignores writes. Reads show the array contents
// directly, so a same-cycle write becomes visible only after the edge.
module regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd0_num,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_num,
  output logic [DATA_W-1:0] rd1_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_NUM = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reset has priority over a write in the same cycle; R0 is never written,
  // so its storage stays at the reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_num != ZERO_NUM)) begin
      regs[wr_num] <= wr_data;
    end
  end

  // R0 is forced to zero at the mux as well, independent of its storage.
  assign rd0_data = (rd0_num == ZERO_NUM) ? '0 : regs[rd0_num];
  assign rd1_data = (rd1_num == ZERO_NUM) ? '0 : regs[rd1_num];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed bench for regfile. Inputs change 1 time unit after a
// rising edge, outputs are sampled 1 time unit after that.
module tb_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [4:0]  rd0_num;
  logic [31:0] rd0_data;
  logic [4:0]  rd1_num;
  logic [31:0] rd1_data;

  int checks   = 0;
  int failures = 0;

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_num   (wr_num),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd0_num  (rd0_num),
    .rd0_data (rd0_data),
    .rd1_num  (rd1_num),
    .rd1_data (rd1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int k);
    logic [31:0] v;
    v = 32'h0101_0101 * 32'(k);
    return v;
  endfunction

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_num  = 5'd0;
    wr_data = 32'h0;
    rd0_num = 5'd0;
    rd1_num = 5'd0;

    // Reset for one edge, then sweep both read ports.
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd0_num = 5'(i);
      rd1_num = 5'(31 - i);
      #1;
      check($sformatf("reset_rd0_r%0d", i), rd0_data, 32'h0);
      check($sformatf("reset_rd1_r%0d", 31 - i), rd1_data, 32'h0);
    end

    // Basic write to SP, both ports read the same register.
    wr_num = 5'd29; wr_data = 32'h8012_0000; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd0_num = 5'd29; rd1_num = 5'd29;
    #1;
    check("basic_rd0_r29", rd0_data, 32'h8012_0000);
    check("basic_rd1_r29", rd1_data, 32'h8012_0000);

    // R0 protection.
    wr_num = 5'd0; wr_data = 32'hFFFF_FFFF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd0_num = 5'd0; rd1_num = 5'd0;
    #1;
    check("r0_rd0", rd0_data, 32'h0);
    check("r0_rd1", rd1_data, 32'h0);

    // Collision: old value before the edge, new value after.
    rd1_num = 5'd31;
    wr_num = 5'd31; wr_data = 32'h8002_0008; wr_en = 1'b1;
    #1;
    check("collide_before", rd1_data, 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check("collide_after", rd1_data, 32'h8002_0008);

    // Enable gating: seed R5, then a disabled write must not change it.
    wr_num = 5'd5; wr_data = 32'h0000_AAAA; wr_en = 1'b1;
    tick();
    wr_num = 5'd5; wr_data = 32'h0000_1234; wr_en = 1'b0;
    tick();
    rd0_num = 5'd5;
    #1;
    check("wren0_r5", rd0_data, 32'h0000_AAAA);

    // Last write wins on back-to-back writes to one register.
    wr_num = 5'd7; wr_data = 32'h1111_1111; wr_en = 1'b1;
    tick();
    wr_num = 5'd7; wr_data = 32'h2222_2222; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd1_num = 5'd7;
    #1;
    check("lastwins_r7", rd1_data, 32'h2222_2222);

    // Reset beats a simultaneous write and clears everything.
    reset = 1'b1; wr_num = 5'd5; wr_data = 32'h0000_1234; wr_en = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    rd0_num = 5'd5; rd1_num = 5'd29;
    #1;
    check("rstprio_r5", rd0_data, 32'h0);
    check("rstprio_r29", rd1_data, 32'h0);
    rd0_num = 5'd31; rd1_num = 5'd7;
    #1;
    check("rstprio_r31", rd0_data, 32'h0);
    check("rstprio_r7", rd1_data, 32'h0);

    // Full sweep: Rk = k*0x01010101 on consecutive cycles.
    for (int k = 1; k < 32; k++) begin
      wr_num = 5'(k); wr_data = sweep_val(k); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rd0_num = 5'(k);
      rd1_num = 5'(31 - k);
      #1;
      check($sformatf("sweep_rd0_r%0d", k), rd0_data, sweep_val(k));
      check($sformatf("sweep_rd1_r%0d", 31 - k), rd1_data, sweep_val(31 - k));
    end
    for (int n = 0; n < 40; n++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      rd0_num = 5'(a);
      rd1_num = 5'(b);
      #1;
      check($sformatf("rand_rd0_r%0d", a), rd0_data, sweep_val(a));
      check($sformatf("rand_rd1_r%0d", b), rd1_data, sweep_val(b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
